mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage data access engine that sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It takes the latched load/store request (address, store data, size, signedness), checks alignment, and drives the data SRAM-like bus with an address/data two-phase handshake. It returns sign- or zero-extended load data. While a bus transaction is outstanding it raises a stall to the hazard unit, and it absorbs exception flushes without corrupting the bus.

## Interface
- No parameters. The only configuration is the macro in Configuration.
- clk  in  1  pipeline clock; every register updates on the rising edge.
- rset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- mem_read  in  1  the instruction in MEM is a load.
- mem_write  in  1  the instruction in MEM is a store.
- mem_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- load_unsigned  in  1  zero-extend (LBU/LHU) instead of sign-extend.
- lr_op  in  2  0 = normal, 1 = LWL/SWL, 2 = LWR/SWR. Ignored when LWLR_EN is undefined.
- addr  in  32  effective address, taken from the ALU result.
- wdata  in  32  store data (rt value).
- rt_old  in  32  current rt value, used for LWL/LWR merging.
- flush  in  1  exception/ERET flush of the MEM stage.
- pipe_go  in  1  MEM/WB will capture this cycle (no downstream stall).
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  bus transfer size.
- data_addr  out  32  bus address.
- data_wdata  out  32  bus write data.
- data_addr_ok  in  1  bus has accepted the request.
- data_data_ok  in  1  read data is valid or the write has completed.
- data_rdata  in  32  bus read data.
- load_result  out  32  extended/merged load value for writeback.
- mem_stall  out  1  hold IF through MEM.
- adel  out  1  load address error.
- ades  out  1  store address error.
- badvaddr  out  32  faulting address; equals addr whenever adel or ades is 1.

## Operation
- access = (mem_read | mem_write) & ~misaligned & ~flush.
- misaligned:
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 0 when lr_op = 0.
- adel = mem_read & misaligned. ades = mem_write & misaligned. Both are combinational, and no bus request is issued for a misaligned access.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE: data_req = access. If data_addr_ok, go to WAIT; otherwise go to REQ.
  - REQ: data_req = 1 and all request fields are held stable. On data_addr_ok, go to WAIT. If flush is 1 and data_addr_ok is 0, withdraw the request and go to IDLE.
  - WAIT: on data_data_ok, capture the result into rdata_q. Then go to IDLE if pipe_go, else go to DONE. If flush occurs without data_ok, go to DRAIN.
  - DONE: no request is issued. load_result = rdata_q. Go to IDLE when pipe_go or flush.
  - DRAIN: data_req = 0. Discard the next data_data_ok, then go to IDLE. mem_stall = 1.
- data_size = mem_size. data_wr = mem_write.
- Byte stores: data_wdata = {4{wdata[7:0]}}. Halfword stores: {2{wdata[15:0]}}. Word stores: wdata.
- Load extension selects the byte or halfword from data_rdata using addr[1:0], then sign- or zero-extends it to 32 bits.
- mem_stall = 1 in each of these cases:
  - IDLE with access and no data_data_ok possible (i.e. whenever access);
  - REQ;
  - WAIT without data_data_ok;
  - DRAIN.
- mem_stall = 0 in DONE.
- load_result = extended data_rdata in the WAIT cycle where data_data_ok is 1; otherwise it is rdata_q.

## Timing
- Reset: while rset = 0 at a clock edge, state becomes IDLE and rdata_q becomes 0. Outputs while rset = 0: data_req = 0, mem_stall = 0, adel = 0, ades = 0, load_result = 0. Reset mid-transaction abandons it; the bus must also be reset.
- data_addr_ok may be asserted in the same cycle as data_req. data_data_ok arrives at least one cycle after data_addr_ok.
- Minimum latency: request in cycle N, addr_ok in N, data_ok in N+1. The stall is released in N+1 and the result is valid in N+1.
- At most one outstanding transaction at a time.
- flush and data_data_ok in the same WAIT cycle: the data is accepted, then the state goes to IDLE and the result is unused.

## Configuration
- LWLR_EN defined:
  - LWL/LWR merge bytes of data_rdata into rt_old according to addr[1:0], using a word-aligned data_addr and data_size = 2.
  - SWL/SWR issue a word-aligned store with shifted data. data_size is 0/1/2 based on the byte count, and data_addr is adjusted accordingly. These accesses never raise an address error.
- LWLR_EN undefined: lr_op is ignored, and all accesses are normal.

## Test plan
- Unsigned byte load (LBU) at 0x1000_0003; bus addr_ok in the request cycle, data_ok 2 cycles later with rdata 0x80FF_1234 → load_result = 0x0000_0080. mem_stall is high for 2 cycles.
- LH at 0x1000_0001 → adel = 1, badvaddr = 0x1000_0001, data_req stays 0, mem_stall = 0.
- SB with wdata 0x0000_00A5 → data_wdata = 0xA5A5_A5A5, data_size = 0, data_wr = 1.
- LW in WAIT, then flush arrives, then data_ok arrives 3 cycles later → DRAIN for 3 cycles, then IDLE. No stale load_result; a subsequent LW completes correctly.
- LW completes while pipe_go = 0 for 2 cycles → DONE holds load_result and issues no second data_req. Return to IDLE on pipe_go.
- With LWLR_EN defined: LWL at addr[1:0] = 1, rdata 0x1122_3344, rt_old 0xAABB_CCDD → load_result = 0x3344_CCDD.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: alignment check, SRAM-like two-phase bus handshake and
// load extension. Define LWLR_EN to add LWL/LWR/SWL/SWR (unaligned word merge) support.
module mem_access_unit (
   input  logic        clk,
   input  logic        rset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        load_unsigned,
   input  logic [1:0]  lr_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] rt_old,
   input  logic        flush,
   input  logic        pipe_go,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic [31:0] load_result,
   output logic        mem_stall,
   output logic        adel,
   output logic        ades,
   output logic [31:0] badvaddr
);
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   logic [2:0]  state_r;
   logic [2:0]  state_nxt_s;
   logic [31:0] rdata_q_r;
   logic        lr_left_s;
   logic        lr_right_s;
   logic        lr_s;
   logic        size_half_s;
   logic        size_word_s;
   logic        misaligned_s;
   logic        access_s;
   logic        capture_s;
   logic        req_s;
   logic        stall_s;
   logic [31:0] shifted_s;
   logic [31:0] ext_norm_s;
   logic [31:0] ext_s;

`ifdef LWLR_EN
   assign lr_left_s  = (lr_op == 2'd1);
   assign lr_right_s = (lr_op == 2'd2);
`else
   logic [33:0] unused_lr_s;
   assign unused_lr_s = {lr_op, rt_old};
   assign lr_left_s   = 1'b0;
   assign lr_right_s  = 1'b0;
`endif

   assign lr_s         = lr_left_s | lr_right_s;
   assign size_half_s  = (mem_size == 2'd1);
   assign size_word_s  = mem_size[1];
   // Unaligned-word ops are word-aligned by construction and can never fault
   assign misaligned_s = ~lr_s & ((size_half_s & addr[0]) |
                                  (size_word_s & (addr[1:0] != 2'b00)));
   assign access_s     = (mem_read | mem_write) & ~misaligned_s & ~flush;

   assign data_wr  = mem_write;
   assign badvaddr = addr;
   assign adel     = rset & mem_read & misaligned_s;
   assign ades     = rset & mem_write & misaligned_s;

   // Bus request fields; unaligned-word ops rewrite address, size and lane placement
   always_comb begin
      data_addr = addr;
      data_size = size_word_s ? 2'd2 : mem_size;
      case (mem_size)
         2'd0:    data_wdata = {4{wdata[7:0]}};
         2'd1:    data_wdata = {2{wdata[15:0]}};
         default: data_wdata = wdata;
      endcase
`ifdef LWLR_EN
      if (lr_s & mem_read) begin
         data_addr = {addr[31:2], 2'b00};
         data_size = 2'd2;
      end else if (lr_left_s & mem_write) begin
         data_addr = {addr[31:2], 2'b00};
         case (addr[1:0])
            2'd0:    begin data_size = 2'd0; data_wdata = {24'd0, wdata[31:24]}; end
            2'd1:    begin data_size = 2'd1; data_wdata = {16'd0, wdata[31:16]}; end
            2'd2:    begin data_size = 2'd2; data_wdata = {8'd0, wdata[31:8]};   end
            default: begin data_size = 2'd2; data_wdata = wdata;                 end
         endcase
      end else if (lr_right_s & mem_write) begin
         data_addr = addr;
         case (addr[1:0])
            2'd0:    begin data_size = 2'd2; data_wdata = wdata;                 end
            2'd1:    begin data_size = 2'd2; data_wdata = {wdata[23:0], 8'd0};  end
            2'd2:    begin data_size = 2'd1; data_wdata = {wdata[15:0], 16'd0}; end
            default: begin data_size = 2'd0; data_wdata = {wdata[7:0], 24'd0};  end
         endcase
      end else begin
         data_addr = addr;
      end
`endif
   end

   assign shifted_s = data_rdata >> {addr[1:0], 3'b000};

   // Byte/halfword lane select followed by sign or zero extension
   always_comb begin
      case (mem_size)
         2'd0:    ext_norm_s = {{24{~load_unsigned & shifted_s[7]}}, shifted_s[7:0]};
         2'd1:    ext_norm_s = {{16{~load_unsigned & shifted_s[15]}}, shifted_s[15:0]};
         default: ext_norm_s = data_rdata;
      endcase
   end

`ifdef LWLR_EN
   // LWL/LWR merge of the loaded bytes into the old rt value
   always_comb begin
      if (lr_left_s) begin
         case (addr[1:0])
            2'd0:    ext_s = {data_rdata[7:0], rt_old[23:0]};
            2'd1:    ext_s = {data_rdata[15:0], rt_old[15:0]};
            2'd2:    ext_s = {data_rdata[23:0], rt_old[7:0]};
            default: ext_s = data_rdata;
         endcase
      end else if (lr_right_s) begin
         case (addr[1:0])
            2'd0:    ext_s = data_rdata;
            2'd1:    ext_s = {rt_old[31:24], data_rdata[31:8]};
            2'd2:    ext_s = {rt_old[31:16], data_rdata[31:16]};
            default: ext_s = {rt_old[31:8], data_rdata[31:24]};
         endcase
      end else begin
         ext_s = ext_norm_s;
      end
   end
`else
   assign ext_s = ext_norm_s;
`endif

   // Transaction sequencing, bus request and pipeline stall
   always_comb begin
      state_nxt_s = state_r;
      req_s       = 1'b0;
      stall_s     = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req_s   = access_s;
            stall_s = access_s;
            if (access_s) begin
               state_nxt_s = data_addr_ok ? ST_WAIT : ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            req_s   = 1'b1;
            stall_s = 1'b1;
            if (data_addr_ok) begin
               state_nxt_s = ST_WAIT;
            end else if (flush) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            stall_s   = ~data_data_ok;
            capture_s = data_data_ok;
            if (data_data_ok) begin
               state_nxt_s = (pipe_go | flush) ? ST_IDLE : ST_DONE;
            end else if (flush) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_nxt_s = (pipe_go | flush) ? ST_IDLE : ST_DONE;
         end
         ST_DRAIN: begin
            stall_s     = 1'b1;
            state_nxt_s = data_data_ok ? ST_IDLE : ST_DRAIN;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign data_req    = rset & req_s;
   assign mem_stall   = rset & stall_s;
   assign load_result = ~rset ? 32'd0 : (capture_s ? ext_s : rdata_q_r);

   // State and captured load data; a drained response never reaches rdata_q_r
   always_ff @(posedge clk) begin
      if (!rset) begin
         state_r   <= ST_IDLE;
         rdata_q_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         if (capture_s) begin
            rdata_q_r <= ext_s;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level reference model checked every
// cycle, plus literal expectations for the main load/store/flush/hold cases.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rset;
   logic        mem_read, mem_write, load_unsigned, flush, pipe_go;
   logic [1:0]  mem_size, lr_op;
   logic [31:0] addr, wdata, rt_old;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata, load_result, badvaddr;
   logic        mem_stall, adel, ades;

   int n_vec  = 0;
   int n_fail = 0;
   bit lr_mode = 1'b0;
   logic [31:0] last_lit;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rset(rset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .load_unsigned(load_unsigned), .lr_op(lr_op),
      .addr(addr), .wdata(wdata), .rt_old(rt_old), .flush(flush), .pipe_go(pipe_go),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata), .load_result(load_result),
      .mem_stall(mem_stall), .adel(adel), .ades(ades), .badvaddr(badvaddr)
   );

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk32(name, 32'(act), 32'(exp));
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                            input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      int k;
      k = int'(a % 32'd4);
      if (sz == 2'd0) begin
         v = (rd >> (8 * k)) & 32'h0000_00FF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (rd >> (8 * k)) & 32'h0000_FFFF;
         if (!uns && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd1) return (a % 32'd2) != 32'd0;
      if (sz >= 2'd2) return (a % 32'd4) != 32'd0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd0) return (wd & 32'h0000_00FF) * 32'h0101_0101;
      if (sz == 2'd1) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic bit ref_go(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] a, input logic fl);
      return (rd || wr) && !ref_mis(sz, a) && !fl;
   endfunction

   // asked: request on the bus, not yet accepted; inflight: accepted, data pending;
   // held: result captured but the pipe has not moved; drain: flushed, response pending
   bit m_asked = 1'b0, m_inflight = 1'b0, m_held = 1'b0, m_drain = 1'b0;
   logic [31:0] m_res = 32'd0;

   always @(posedge clk) begin
      if (!rset) begin
         m_asked <= 1'b0; m_inflight <= 1'b0; m_held <= 1'b0; m_drain <= 1'b0;
         m_res   <= 32'd0;
      end else if (m_asked) begin
         if (data_addr_ok) begin
            m_asked <= 1'b0; m_inflight <= 1'b1;
         end else if (flush) begin
            m_asked <= 1'b0;
         end
      end else if (m_inflight) begin
         if (data_data_ok) begin
            m_inflight <= 1'b0;
            m_res      <= ref_load(mem_size, load_unsigned, addr, data_rdata);
            m_held     <= !(pipe_go || flush);
         end else if (flush) begin
            m_inflight <= 1'b0; m_drain <= 1'b1;
         end
      end else if (m_held) begin
         if (pipe_go || flush) m_held <= 1'b0;
      end else if (m_drain) begin
         if (data_data_ok) m_drain <= 1'b0;
      end else if (ref_go(mem_read, mem_write, mem_size, addr, flush)) begin
         if (data_addr_ok) m_inflight <= 1'b1;
         else              m_asked    <= 1'b1;
      end
   end

   bit e_mis, e_go, e_idle, e_req, e_stall, e_adel, e_ades;
   logic [31:0] e_res;

   // every-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (!lr_mode) begin
         e_mis   = ref_mis(mem_size, addr);
         e_go    = ref_go(mem_read, mem_write, mem_size, addr, flush);
         e_idle  = !(m_asked || m_inflight || m_held || m_drain);
         e_req   = m_asked || (e_idle && e_go);
         e_stall = m_asked || m_drain || (m_inflight && !data_data_ok) || (e_idle && e_go);
         e_res   = (m_inflight && data_data_ok) ?
                   ref_load(mem_size, load_unsigned, addr, data_rdata) : m_res;
         e_adel  = mem_read && e_mis;
         e_ades  = mem_write && e_mis;
         if (!rset) begin
            e_req = 1'b0; e_stall = 1'b0; e_res = 32'd0; e_adel = 1'b0; e_ades = 1'b0;
         end
         chk1("model_data_req", data_req, e_req);
         chk1("model_mem_stall", mem_stall, e_stall);
         chk1("model_adel", adel, e_adel);
         chk1("model_ades", ades, e_ades);
         chk32("model_load_result", load_result, e_res);
         if (e_adel || e_ades) chk32("model_badvaddr", badvaddr, addr);
         if (e_req) begin
            chk32("model_data_addr", data_addr, addr);
            chk1("model_data_wr", data_wr, mem_write);
            chk32("model_data_size", 32'(data_size), (mem_size == 2'd3) ? 32'd2 : 32'(mem_size));
            chk32("model_data_wdata", data_wdata, ref_wdata(mem_size, wdata));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0; pipe_go = 1'b1;
      data_rdata   = 32'd0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic set_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
      mem_read = rd; mem_write = wr; mem_size = sz; load_unsigned = uns; addr = a; wdata = wd;
   endtask

   typedef struct packed {
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] rd;
      logic [31:0] exp;
   } ld_t;
   ld_t ld_tab [0:5];

   initial begin
      rset = 1'b0; lr_op = 2'd0; rt_old = 32'd0;
      set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
      flush = 1'b0; pipe_go = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      data_rdata = 32'd0; last_lit = 32'd0;
      ld_tab = '{
         '{2'd0, 1'b0, 32'h5000_0001, 32'h0000_8000, 32'hFFFF_FF80},
         '{2'd0, 1'b0, 32'h5000_0000, 32'h0000_007F, 32'h0000_007F},
         '{2'd1, 1'b0, 32'h5000_0002, 32'h8001_0000, 32'hFFFF_8001},
         '{2'd1, 1'b1, 32'h5000_0002, 32'h8001_0000, 32'h0000_8001},
         '{2'd2, 1'b0, 32'h5000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
         '{2'd0, 1'b1, 32'h5000_0002, 32'h00C3_0000, 32'h0000_00C3}};

      // reset with an access presented: everything quiet
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'd0);
      data_addr_ok = 1'b1; settle();
      chk1("rst_req", data_req, 1'b0); chk1("rst_stall", mem_stall, 1'b0);
      chk32("rst_result", load_result, 32'd0);
      next_cycle(); set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0); settle();
      next_cycle(); rset = 1'b1; settle();
      chk1("idle_stall", mem_stall, 1'b0);

      // LBU 0x1000_0003, addr_ok at once, data_ok two cycles later
      next_cycle(); set_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'd0);
      data_addr_ok = 1'b1; settle();
      chk1("lbu_req", data_req, 1'b1); chk1("lbu_stall_c0", mem_stall, 1'b1);
      chk32("lbu_addr", data_addr, 32'h1000_0003);
      next_cycle(); settle();
      chk1("lbu_stall_c1", mem_stall, 1'b1); chk1("lbu_noreq_c1", data_req, 1'b0);
      next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h80FF_1234; settle();
      chk1("lbu_stall_c2", mem_stall, 1'b0); chk32("lbu_result", load_result, 32'h0000_0080);
      next_cycle(); set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0); settle();
      chk32("lbu_result_held", load_result, 32'h0000_0080);

      // back-to-back minimum-latency loads of every size/extension
      for (int i = 0; i < 6; i++) begin
         next_cycle(); set_req(1'b1, 1'b0, ld_tab[i].sz, ld_tab[i].uns, ld_tab[i].a, 32'd0);
         data_addr_ok = 1'b1; settle();
         next_cycle(); data_data_ok = 1'b1; data_rdata = ld_tab[i].rd; settle();
         chk32($sformatf("ld%0d_result", i), load_result, ld_tab[i].exp);
         chk1($sformatf("ld%0d_stall", i), mem_stall, 1'b0);
         last_lit = ld_tab[i].exp;
      end

      // LH misaligned: address error, no bus request, no stall
      next_cycle(); set_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h1000_0001, 32'd0); settle();
      chk1("lh_adel", adel, 1'b1); chk1("lh_ades", ades, 1'b0);
      chk32("lh_badvaddr", badvaddr, 32'h1000_0001);
      chk1("lh_req", data_req, 1'b0); chk1("lh_stall", mem_stall, 1'b0);

      // LW flushed in WAIT, response 3 cycles later is drained
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000_0000, 32'd0);
      data_addr_ok = 1'b1; settle();
      next_cycle(); flush = 1'b1; settle();
      chk1("fl_stall_wait", mem_stall, 1'b1);
      next_cycle(); set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0); settle();
      chk1("drain1_stall", mem_stall, 1'b1); chk1("drain1_req", data_req, 1'b0);
      next_cycle(); settle();
      chk1("drain2_stall", mem_stall, 1'b1);
      next_cycle(); data_data_ok = 1'b1; data_rdata = 32'hBADB_AD00; settle();
      chk1("drain3_stall", mem_stall, 1'b1); chk32("drain3_result", load_result, last_lit);
      next_cycle(); settle();
      chk1("post_drain_stall", mem_stall, 1'b0);
      chk32("post_drain_result", load_result, last_lit);
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000_0004, 32'd0);
      data_addr_ok = 1'b1; settle();
      chk1("after_drain_req", data_req, 1'b1);
      next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h1234_5678; settle();
      chk32("after_drain_result", load_result, 32'h1234_5678);

      // LW completes while MEM/WB is stalled for two cycles
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000_0008, 32'd0);
      data_addr_ok = 1'b1; settle();
      next_cycle(); data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; pipe_go = 1'b0; settle();
      chk32("hold_c0_result", load_result, 32'hCAFE_F00D);
      chk1("hold_c0_stall", mem_stall, 1'b0);
      next_cycle(); pipe_go = 1'b0; settle();
      chk1("hold_c1_req", data_req, 1'b0); chk1("hold_c1_stall", mem_stall, 1'b0);
      chk32("hold_c1_result", load_result, 32'hCAFE_F00D);
      next_cycle(); settle();
      chk1("hold_go_req", data_req, 1'b0);
      chk32("hold_go_result", load_result, 32'hCAFE_F00D);

      // flush coinciding with data_ok goes straight back to IDLE
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000_000C, 32'd0);
      data_addr_ok = 1'b1; settle();
      next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D; flush = 1'b1;
      pipe_go = 1'b0; settle();
      chk1("flok_stall", mem_stall, 1'b0);
      // new access accepted immediately; then withdrawn from REQ by a flush
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000_0010, 32'd0); settle();
      chk1("flok_idle_req", data_req, 1'b1);
      chk32("flok_result", load_result, 32'h0BAD_F00D);
      next_cycle(); flush = 1'b1; settle();
      chk1("req_flush_req", data_req, 1'b1); chk1("req_flush_stall", mem_stall, 1'b1);
      next_cycle(); set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0); settle();
      chk1("withdrawn_req", data_req, 1'b0); chk1("withdrawn_stall", mem_stall, 1'b0);

      // stores: SB replication, SH with a held request, misaligned SW
      next_cycle(); set_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h2000_0002, 32'h0000_00A5);
      data_addr_ok = 1'b1; settle();
      chk32("sb_wdata", data_wdata, 32'hA5A5_A5A5); chk32("sb_size", 32'(data_size), 32'd0);
      chk1("sb_wr", data_wr, 1'b1); chk1("sb_req", data_req, 1'b1);
      next_cycle(); data_data_ok = 1'b1; settle();
      chk1("sb_done_stall", mem_stall, 1'b0);
      next_cycle(); set_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h2000_0002, 32'h1234_BEEF); settle();
      chk32("sh_wdata", data_wdata, 32'hBEEF_BEEF);
      next_cycle(); settle();
      chk1("sh_req_held", data_req, 1'b1); chk1("sh_stall_held", mem_stall, 1'b1);
      next_cycle(); data_addr_ok = 1'b1; settle();
      next_cycle(); data_data_ok = 1'b1; settle();
      chk1("sh_done_stall", mem_stall, 1'b0);
      next_cycle(); set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h2000_0001, 32'h0000_0001); settle();
      chk1("sw_ades", ades, 1'b1); chk1("sw_adel", adel, 1'b0); chk1("sw_req", data_req, 1'b0);

`ifndef LWLR_EN
      // without LWLR_EN an lr_op word access is just a misaligned LW
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h7000_0001, 32'd0); lr_op = 2'd1;
      settle();
      chk1("lr_ignored_adel", adel, 1'b1); chk1("lr_ignored_req", data_req, 1'b0);
      lr_op = 2'd0;
`endif

      // reset in the middle of a transaction abandons it
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h6000_0000, 32'd0);
      data_addr_ok = 1'b1; settle();
      next_cycle(); rset = 1'b0; settle();
      chk1("midrst_stall", mem_stall, 1'b0); chk32("midrst_result", load_result, 32'd0);
      next_cycle(); rset = 1'b1; set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0); settle();
      chk1("after_rst_stall", mem_stall, 1'b0);
      chk32("after_rst_result", load_result, 32'd0);

`ifdef LWLR_EN
      // LWL at byte offset 1 merges into rt_old
      lr_mode = 1'b1;
      next_cycle(); set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h7000_0001, 32'd0); lr_op = 2'd1;
      rt_old = 32'hAABB_CCDD; data_addr_ok = 1'b1; settle();
      chk32("lwl_addr", data_addr, 32'h7000_0000); chk1("lwl_adel", adel, 1'b0);
      chk32("lwl_size", 32'(data_size), 32'd2);
      next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h1122_3344; settle();
      chk32("lwl_result", load_result, 32'h3344_CCDD);
      next_cycle(); set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0); lr_op = 2'd0; settle();
`endif

      next_cycle(); settle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
